wb_burst_reader: RTL
====================

// Module: wb_burst_reader
// PURPOSE
//  Wishbone B3 read master: fetches cmd_len 32-bit words from cmd_adr using incrementing
//  bursts (CTI 010, BTE 00) and delivers them on a valid/ready stream through an internal FIFO.
//  Initiator side of the burst-capable slaves on the SoC bus (ROM, RAM).
//  Used for boot-image copy and DMA-style block fetch.
// PARAMETERS
//  FIFO_DEPTH  8   output FIFO entries; power of 2, >=4
//  LEN_W       16  width of cmd_len (words)
//  RTY_LIMIT   4   max consecutive retries per beat (used only with WB_BURST_READER_RTY_EN)
// PORTS
//  wb_clk      in   1      clock
//  wb_rst_n    in   1      synchronous reset, active-low
//  cmd_valid   in   1      command request
//  cmd_ready   out  1      high in IDLE only
//  cmd_adr     in   32     byte start address; bits [1:0] ignored (forced 0)
//  cmd_len     in   LEN_W  word count; 0 = no-op
//  busy        out  1      not IDLE
//  done        out  1      1-cycle pulse at command end
//  err         out  1      valid with done: 1 = aborted by bus error
//  wb_adr_o    out  32     word-aligned address of current beat
//  wb_cti_o    out  3      010 = mid-burst, 111 = last beat
//  wb_bte_o    out  2      always 00
//  wb_we_o     out  1      always 0
//  wb_sel_o    out  4      always 4'hF
//  wb_cyc_o    out  1      bus cycle
//  wb_stb_o    out  1      strobe
//  wb_dat_i    in   32     read data
//  wb_ack_i    in   1      ack
//  wb_err_i    in   1      error
//  wb_rty_i    in   1      retry
//  dout_valid  out  1      FIFO not empty
//  dout_ready  in   1      consumer accepts; pop = dout_valid & dout_ready
//  dout_data   out  32     FIFO head word
// BEHAVIOUR
//  - Reset (wb_rst_n=0 at posedge): state=IDLE; cyc/stb/done/err=0; cti=000; adr=0; FIFO
//    emptied (dout_valid=0). Reset mid-burst drops cyc next edge; no done pulse.
//  - Beat = cycle with wb_cyc_o & wb_stb_o & wb_ack_i; wb_dat_i is pushed to the FIFO same edge.
//    Beats with stb low are ignored.
//  - FSM IDLE -> BURST -> IDLE; ERR_WAIT is a single-cycle state entered only with the macro.
//  - IDLE: accept on cmd_valid & cmd_ready. cmd_len=0: done=1, err=0 next cycle, bus untouched.
//    Else latch adr/len; cyc=stb=1 next cycle.
//  - BURST: after each beat adr += 4 (wraps at 2^32) and remaining -= 1.
//    cti=111 when remaining==1, else 010. Last beat: cyc=stb=0, done=1 next cycle.
//  - Flow control: stb=1 only while FIFO free slots >=2, counting the same-cycle pop.
//    Covers one cycle of registered-ack latency. cyc stays high during stalls; adr holds.
//  - FIFO: simultaneous push+pop when full is legal (count unchanged). Never overflows by
//    construction. Ack while FIFO full is an assertion failure.
//  - wb_err_i during cyc: abort; cyc=stb=0 next edge; done=1, err=1. Words already
//    pushed stay in the FIFO.
//  - wb_rty_i (macro off): treated exactly as wb_err_i.
//  - Simultaneous ack+err: err wins, data is discarded.
//  - done/err are asserted independently of FIFO drain. Consumer tracks outstanding words.
// CONFIGURATION
//  WB_BURST_READER_RTY_EN defined:
//   - wb_rty_i drops cyc for one cycle (ERR_WAIT), then re-issues the same beat.
//   - adr and remaining are unchanged on retry.
//   - After RTY_LIMIT consecutive retries on one beat: abort as err=1.
//   - The retry counter clears on each successful beat.
//  Not defined: rty handled as error; the RTY_LIMIT counter is not built.
// TESTING
//  1 len=4, adr=0x100, slave acks every cycle, dout_ready=1 -> adr 100,104,108,10C;
//    cti 010,010,010,111; 4 words in order; done 1 cycle after last ack, err=0.
//  2 len=12, dout_ready=0 -> stb drops with FIFO_DEPTH-1 words stored, cyc stays high.
//    Raise ready: burst resumes at the next address; all 12 words in order, no loss or dup.
//  3 len=0 -> done=1, err=0 one cycle after accept; wb_cyc_o never asserted.
//  4 len=8, wb_err_i on 3rd beat -> cyc low next edge; done=err=1; exactly 2 words delivered.
//  5 macro on: rty on beat 2 twice, then ack -> beat 2 adr reissued twice; 8 correct words.
//    5 rty on the same beat (RTY_LIMIT=4) -> err=1.
//  6 adr=0xFFFFFFF8, len=4 -> adr sequence FFFFFFF8, FFFFFFFC, 0, 4.
//    Reset asserted mid-burst -> cyc=0, dout_valid=0, no done.

Source files
------------

// File: rtl/wb_burst_reader_if.sv
// Signal bundle between the burst reader and its environment: command port,
// Wishbone B3 read-master signals and the output word stream.
// The master modport is the reader side; the slave modport is the environment side.
interface wb_burst_reader_if #(
  parameter int LEN_W = 16
);
  // command
  logic             cmd_valid;
  logic             cmd_ready;
  logic [31:0]      cmd_adr;
  logic [LEN_W-1:0] cmd_len;
  logic             busy;
  logic             done;
  logic             err;
  // wishbone
  logic [31:0]      wb_adr_o;
  logic [2:0]       wb_cti_o;
  logic [1:0]       wb_bte_o;
  logic             wb_we_o;
  logic [3:0]       wb_sel_o;
  logic             wb_cyc_o;
  logic             wb_stb_o;
  logic [31:0]      wb_dat_i;
  logic             wb_ack_i;
  logic             wb_err_i;
  logic             wb_rty_i;
  // output stream
  logic             dout_valid;
  logic             dout_ready;
  logic [31:0]      dout_data;

  modport master (
    input  cmd_valid, cmd_adr, cmd_len,
    output cmd_ready, busy, done, err,
    output wb_adr_o, wb_cti_o, wb_bte_o, wb_we_o, wb_sel_o, wb_cyc_o, wb_stb_o,
    input  wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i,
    output dout_valid, dout_data,
    input  dout_ready
  );

  modport slave (
    output cmd_valid, cmd_adr, cmd_len,
    input  cmd_ready, busy, done, err,
    input  wb_adr_o, wb_cti_o, wb_bte_o, wb_we_o, wb_sel_o, wb_cyc_o, wb_stb_o,
    output wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i,
    input  dout_valid, dout_data,
    output dout_ready
  );
endinterface

// File: rtl/wb_burst_reader.sv
// Wishbone B3 incrementing-burst read master feeding a valid/ready word stream via an internal FIFO.
// Latency: cyc/stb rise one cycle after command accept; ack'd words are readable one cycle later; done one cycle after the last beat.
// Backpressure: stb is withheld while fewer than 2 FIFO slots are free (same-cycle pop counted); cyc stays high and adr holds.
// Optional: define WB_BURST_READER_RTY_EN to retry beats on wb_rty_i (up to RTY_LIMIT times) instead of aborting.
module wb_burst_reader #(
  parameter int FIFO_DEPTH = 8,
  parameter int LEN_W      = 16,
  parameter int RTY_LIMIT  = 4
) (
  input logic               wb_clk,
  input logic               wb_rst_n,
  wb_burst_reader_if.master bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_BURST    = 2'd1,
    S_ERR_WAIT = 2'd2
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [31:0]      r_adr, w_adr_nxt;
  logic [LEN_W-1:0] r_rem, w_rem_nxt;
  logic             r_done, w_done_nxt;
  logic             r_err, w_err_nxt;

  logic [31:0]      r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wptr, r_rptr;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W:0]   w_free;

  logic w_cyc, w_stb, w_room, w_push, w_pop, w_abort, w_retry;

  assign w_cyc  = (r_state == S_BURST);
  assign w_pop  = (r_count != '0) && bus.dout_ready;
  // Free slots after this cycle's pop; two are needed so a late ack always has a home.
  assign w_free = {1'b0, DEPTH_C} - {1'b0, r_count} + {{CNT_W{1'b0}}, w_pop};
  assign w_room = (w_free >= (CNT_W+1)'(2));
  assign w_stb  = w_cyc && w_room;
  // err and rty both override a simultaneous ack, so the word is never stored.
  assign w_push = w_stb && bus.wb_ack_i && !bus.wb_err_i && !bus.wb_rty_i;

`ifdef WB_BURST_READER_RTY_EN
  localparam int RTY_W = $clog2(RTY_LIMIT + 1);
  logic [RTY_W-1:0] r_rty_cnt;
  logic             w_rty_exhausted;

  assign w_rty_exhausted = (r_rty_cnt == RTY_W'(RTY_LIMIT));
  assign w_retry = w_cyc && bus.wb_rty_i && !bus.wb_err_i && !w_rty_exhausted;
  assign w_abort = w_cyc && (bus.wb_err_i || (bus.wb_rty_i && w_rty_exhausted));

  // Consecutive-retry count for the beat in flight; any stored word or idle time clears it.
  always_ff @(posedge wb_clk) begin
    if (!wb_rst_n || w_push || r_state == S_IDLE) begin
      r_rty_cnt <= '0;
    end else if (w_retry) begin
      r_rty_cnt <= r_rty_cnt + 1'b1;
    end
  end
`else
  logic w_unused_rty_cfg;
  assign w_unused_rty_cfg = (RTY_LIMIT > 0);
  assign w_retry = 1'b0;
  assign w_abort = w_cyc && (bus.wb_err_i || bus.wb_rty_i);
`endif

  // Command sequencing: next state, beat address/remaining count and the done/err pulse.
  always_comb begin
    w_state_nxt = r_state;
    w_adr_nxt   = r_adr;
    w_rem_nxt   = r_rem;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          if (bus.cmd_len == '0) begin
            w_done_nxt = 1'b1;
          end else begin
            w_adr_nxt   = {bus.cmd_adr[31:2], 2'b00};
            w_rem_nxt   = bus.cmd_len;
            w_state_nxt = S_BURST;
          end
        end
      end
      S_BURST: begin
        if (w_abort) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
          w_err_nxt   = 1'b1;
        end else if (w_retry) begin
          w_state_nxt = S_ERR_WAIT;
        end else if (w_push) begin
          w_adr_nxt = r_adr + 32'd4;
          w_rem_nxt = r_rem - 1'b1;
          if (r_rem == LEN_W'(1)) begin
            w_state_nxt = S_IDLE;
            w_done_nxt  = 1'b1;
          end
        end
      end
      S_ERR_WAIT: begin
        w_state_nxt = S_BURST;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // FSM and command registers.
  always_ff @(posedge wb_clk) begin
    if (!wb_rst_n) begin
      r_state <= S_IDLE;
      r_adr   <= '0;
      r_rem   <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_adr   <= w_adr_nxt;
      r_rem   <= w_rem_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
    end
  end

  // FIFO pointers and occupancy; push and pop in one cycle leave the count unchanged.
  always_ff @(posedge wb_clk) begin
    if (!wb_rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO storage; contents need no reset since occupancy gates visibility.
  always_ff @(posedge wb_clk) begin
    if (w_push) r_mem[r_wptr] <= bus.wb_dat_i;
  end

  // A slave must not ack into a full FIFO that is not draining this cycle.
  always_ff @(posedge wb_clk) begin
    if (wb_rst_n) begin
      assert (!(w_cyc && bus.wb_ack_i && (r_count == DEPTH_C) && !w_pop));
    end
  end

  assign bus.cmd_ready  = (r_state == S_IDLE);
  assign bus.busy       = (r_state != S_IDLE);
  assign bus.done       = r_done;
  assign bus.err        = r_err;
  assign bus.wb_adr_o   = r_adr;
  assign bus.wb_cti_o   = !w_cyc ? 3'b000 : (r_rem == LEN_W'(1)) ? 3'b111 : 3'b010;
  assign bus.wb_bte_o   = 2'b00;
  assign bus.wb_we_o    = 1'b0;
  assign bus.wb_sel_o   = 4'hF;
  assign bus.wb_cyc_o   = w_cyc;
  assign bus.wb_stb_o   = w_stb;
  assign bus.dout_valid = (r_count != '0);
  assign bus.dout_data  = r_mem[r_rptr];
endmodule
